// File: rtl/watch_pkg.sv
// Shared constants and types for the watch front end and mode modules.
package watch_pkg;

    localparam int unsigned CLK_HZ = 100_000_000;

    // 10 ms debounce, 500 ms long press, 100 ms auto-repeat period
    localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;
    localparam int unsigned HOLD_CYCLES_DEF     = CLK_HZ / 2;
    localparam int unsigned REPEAT_CYCLES_DEF   = CLK_HZ / 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for an asynchronous board input (buttons and switches).
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Pushbutton front end: synchronise, debounce, then derive press, long-press,
// auto-repeat and release strobes, all as single-clk pulses.
//
//   state  | meaning
//   IDLE   | button released, waiting for a debounced press
//   HOLD   | pressed, timing towards the long-press threshold
//   REPEAT | long press reached, emitting periodic repeat strobes
module button_conditioner
    import watch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic btn_level,
    output logic btn_pulse,
    output logic btn_long,
    output logic btn_release
);

    localparam int unsigned DEB_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int unsigned REP_W  = cnt_width(REPEAT_CYCLES);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    logic btn_s;

    logic             stable_q, stable_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

    btn_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic              level_q, level_d;
    logic              pulse_q, pulse_d;
    logic              long_q, long_d;
    logic              release_q, release_d;

    logic rise;
    logic fall;

    btn_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (btn),
        .sync_o  (btn_s)
    );

    // Counter restarts on any sample that agrees with the accepted level.
    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = '0;
        if (btn_s != stable_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                stable_d  = btn_s;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // Edges of the accepted level, seen one clk before btn_level follows.
    assign rise = stable_q & ~level_q;
    assign fall = ~stable_q & level_q;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        level_d    = stable_q;
        pulse_d    = 1'b0;
        long_d     = 1'b0;
        release_d  = 1'b0;

        // A release wins over any timer expiry on the same clk.
        if (fall) begin
            release_d  = 1'b1;
            state_d    = IDLE;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        pulse_d    = 1'b1;
                        state_d    = HOLD;
                        hold_cnt_d = '0;
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        long_d     = 1'b1;
                        pulse_d    = REPEAT_EN;
                        state_d    = REPEAT;
                        hold_cnt_d = '0;
                        rep_cnt_d  = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                REPEAT: begin
                    if (rep_cnt_q == REP_LAST) begin
                        pulse_d   = REPEAT_EN;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
                end
                default: begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                    rep_cnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q   <= 1'b0;
            deb_cnt_q  <= '0;
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            level_q    <= 1'b0;
            pulse_q    <= 1'b0;
            long_q     <= 1'b0;
            release_q  <= 1'b0;
        end else begin
            stable_q   <= stable_d;
            deb_cnt_q  <= deb_cnt_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            level_q    <= level_d;
            pulse_q    <= pulse_d;
            long_q     <= long_d;
            release_q  <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_pulse   = pulse_q;
    assign btn_long    = long_q;
    assign btn_release = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed scenarios plus random button traffic against a timestamp-based
// reference model of the debounced level and its strobes.
module tb_button_conditioner;

    localparam int D      = 4;
    localparam int H      = 20;
    localparam int R      = 5;
    localparam bit REP_EN = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    logic btn_level, btn_pulse, btn_long, btn_release;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .REPEAT_CYCLES   (R),
        .REPEAT_EN       (REP_EN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .btn_level   (btn_level),
        .btn_pulse   (btn_pulse),
        .btn_long    (btn_long),
        .btn_release (btn_release)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: input pipeline, window of recent synchronised samples,
    // accepted level and the time at which the current press was accepted.
    logic m_s1 = 1'b0, m_s2 = 1'b0, m_stable = 1'b0, m_level = 1'b0;
    logic q_win[$];
    int   m_t    = 0;
    int   m_rise = 0;

    int sc_cyc;
    int pulse_log[$], long_log[$], rel_log[$];
    int level_hi;
    int exp_q[$];

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%b expected=%b", tag, m_t, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input string tag, input int got[$], input int exp[$]);
        chk_int({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk_int({tag, "_cycle"}, got[i], exp[i]);
    endtask

    task automatic begin_scenario();
        sc_cyc = -1;
        pulse_log.delete();
        long_log.delete();
        rel_log.delete();
        level_hi = 0;
    endtask

    task automatic step(input logic b, input logic r);
        logic new_level, new_stable, all_diff;
        logic e_pulse, e_long, e_rel;
        int dt;
        btn = b;
        rst = r;
        @(posedge clk);
        m_t++;
        e_pulse = 1'b0;
        e_long  = 1'b0;
        e_rel   = 1'b0;
        if (r) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_stable = 1'b0; m_level = 1'b0;
            q_win.delete();
        end else begin
            new_level = m_stable;
            q_win.push_back(m_s2);
            if (q_win.size() > D) void'(q_win.pop_front());
            all_diff = (q_win.size() == D);
            foreach (q_win[i]) if (q_win[i] == m_stable) all_diff = 1'b0;
            new_stable = all_diff ? ~m_stable : m_stable;
            m_s2 = m_s1;
            m_s1 = b;
            if (new_level && !m_level) m_rise = m_t;
            e_rel = m_level && !new_level;
            dt = m_t - m_rise;
            if (new_level) begin
                e_long  = (dt == H);
                e_pulse = (dt == 0) || (REP_EN && dt >= H && ((dt - H) % R) == 0);
            end
            m_level  = new_level;
            m_stable = new_stable;
        end
        #1;
        sc_cyc++;
        if (btn_pulse === 1'b1)   pulse_log.push_back(sc_cyc);
        if (btn_long === 1'b1)    long_log.push_back(sc_cyc);
        if (btn_release === 1'b1) rel_log.push_back(sc_cyc);
        if (btn_level === 1'b1)   level_hi++;
        chk("btn_level", btn_level, m_level);
        chk("btn_pulse", btn_pulse, e_pulse);
        chk("btn_long", btn_long, e_long);
        chk("btn_release", btn_release, e_rel);
        chk("pulse_release_excl", btn_pulse & btn_release, 1'b0);
    endtask

    initial begin
        // Reset held with button released
        begin_scenario();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        chk_int("reset_strobes", pulse_log.size() + long_log.size() + rel_log.size(), 0);
        chk_int("reset_level", level_hi, 0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);

        // Clean 12-clk press
        begin_scenario();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        exp_q = '{6};
        chk_log("clean_pulse", pulse_log, exp_q);
        exp_q = '{18};
        chk_log("clean_release", rel_log, exp_q);
        chk_int("clean_long", long_log.size(), 0);

        // Bounce every 2 clks, then settle high
        begin_scenario();
        for (int i = 0; i < 12; i++) step(((i / 2) % 2) == 0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
        exp_q = '{18};
        chk_log("bounce_pulse", pulse_log, exp_q);
        exp_q = '{28};
        chk_log("bounce_release", rel_log, exp_q);

        // 40-clk hold: long press, repeats, release beats the next repeat
        begin_scenario();
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0);
        exp_q = '{6, 26, 31, 36, 41};
        chk_log("hold_pulse", pulse_log, exp_q);
        exp_q = '{26};
        chk_log("hold_long", long_log, exp_q);
        exp_q = '{46};
        chk_log("hold_release", rel_log, exp_q);

        // 3-clk glitch
        begin_scenario();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        chk_int("glitch_level", level_hi, 0);
        chk_int("glitch_strobes", pulse_log.size() + long_log.size() + rel_log.size(), 0);

        // Reset in the middle of a held press
        begin_scenario();
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1);
        chk("rst_mid_level", btn_level, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
        exp_q = '{6, 26, 38, 58, 63, 68, 73};
        chk_log("rst_pulse", pulse_log, exp_q);
        exp_q = '{26, 58};
        chk_log("rst_long", long_log, exp_q);
        exp_q = '{78};
        chk_log("rst_release", rel_log, exp_q);

        // Random run lengths with occasional resets
        for (int n = 0; n < 150; n++) begin
            logic b;
            int len;
            b = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       len = $urandom_range(1, D - 1);
                1:       len = $urandom_range(D, D + 3);
                2:       len = $urandom_range(10, 40);
                default: len = $urandom_range(40, 70);
            endcase
            for (int k = 0; k < len; k++)
                step(b, ($urandom_range(0, 299) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
